// File: rtl/psum_deskew_buffer_pkg.sv
// Shared PE-array constants, used by both the ifmap skew stage and the psum deskew buffer
// so the skew applied on the way in always matches the deskew applied on the way out.
package pe_array_pkg;
  localparam int NUM_COLS    = 4;
  localparam int DATA_W      = 16;
  localparam int MAC_LATENCY = 9;
  localparam int CNT_W       = 16;

  typedef logic [DATA_W-1:0] col_word_t;

  // Column c leaves the array c*lat cycles after column 0; it needs the complementary delay.
  function automatic int col_depth(input int c, input int lat);
    return (NUM_COLS - 1 - c) * lat;
  endfunction
endpackage

// File: rtl/psum_deskew_buffer_if.sv
// South-edge psum bus between the PE array (master) and the deskew buffer (slave).
// Valid-only protocol: there is no ready; every in_valid/out_valid beat is accepted in its own cycle.
interface psum_deskew_buffer_if;
  import pe_array_pkg::*;

  logic                       flush;
  logic                       clr_err;
  logic [NUM_COLS*DATA_W-1:0] psum_in;
  logic [NUM_COLS-1:0]        in_valid;
  logic [NUM_COLS*DATA_W-1:0] psum_out;
  logic                       out_valid;
  logic                       align_err;
  logic [CNT_W-1:0]           out_count;

  modport master (
    output flush, clr_err, psum_in, in_valid,
    input  psum_out, out_valid, align_err, out_count
  );

  modport slave (
    input  flush, clr_err, psum_in, in_valid,
    output psum_out, out_valid, align_err, out_count
  );
endinterface

// File: rtl/psum_deskew_buffer_valid_delay_line.sv
// Fixed-depth shift line carrying {valid, data}; flush clears only the valid bits.
module valid_delay_line #(
  parameter int DEPTH = 9,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);
  logic [DEPTH-1:0] vld;
  logic [WIDTH-1:0] dat [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) dat[i] <= '0;
    end else begin
      // Data keeps shifting during flush; only the qualifiers are dropped.
      vld[0] <= flush ? 1'b0 : in_valid;
      dat[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= flush ? 1'b0 : vld[i-1];
        dat[i] <= dat[i-1];
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];
endmodule

// File: rtl/psum_deskew_buffer.sv
// Realigns the skewed column partial sums leaving the PE array into one vector per cycle,
// flags skew mismatches, and counts emitted vectors.
module psum_deskew_buffer
  import pe_array_pkg::*;
#(
  parameter int LATENCY = MAC_LATENCY
) (
  input  logic                        clk,
  input  logic                        rst,
  psum_deskew_buffer_if.slave         bus
);
  col_word_t                  tap_data [NUM_COLS];
  logic [NUM_COLS-1:0]        dv;
  logic [NUM_COLS-1:0]        dv_eff;
  logic                       all_valid;
  logic                       misaligned;
  logic [NUM_COLS*DATA_W-1:0] tap_vec;

  logic [NUM_COLS*DATA_W-1:0] psum_q;
  logic                       valid_q;
  logic                       err_q;
  logic [CNT_W-1:0]           count_q;

  for (genvar c = 0; c < NUM_COLS - 1; c++) begin : g_line
    valid_delay_line #(
      .DEPTH (col_depth(c, LATENCY)),
      .WIDTH (DATA_W)
    ) u_line (
      .clk       (clk),
      .rst       (rst),
      .flush     (bus.flush),
      .in_valid  (bus.in_valid[c]),
      .in_data   (bus.psum_in[c*DATA_W +: DATA_W]),
      .out_valid (dv[c]),
      .out_data  (tap_data[c])
    );
  end

  // The last column is already the latest to arrive, so it needs no delay.
  assign dv[NUM_COLS-1]       = bus.in_valid[NUM_COLS-1];
  assign tap_data[NUM_COLS-1] = bus.psum_in[(NUM_COLS-1)*DATA_W +: DATA_W];

  always_comb begin
    tap_vec = '0;
    for (int c = 0; c < NUM_COLS; c++) tap_vec[c*DATA_W +: DATA_W] = tap_data[c];
    // A flush cycle neither emits nor judges alignment: its taps are being discarded.
    dv_eff     = bus.flush ? '0 : dv;
    all_valid  = &dv_eff;
    misaligned = (|dv_eff) && !all_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psum_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      valid_q <= all_valid;
      if (all_valid) psum_q <= tap_vec;
      if (misaligned)       err_q <= 1'b1;
      else if (bus.clr_err) err_q <= 1'b0;
      if (all_valid && (count_q != '1)) count_q <= count_q + 1'b1;
    end
  end

  assign bus.psum_out  = psum_q;
  assign bus.out_valid = valid_q;
  assign bus.align_err = err_q;
  assign bus.out_count = count_q;
endmodule

// File: tb/tb_psum_deskew_buffer.sv
// Directed bench for psum_deskew_buffer at LATENCY=9: single vector, streaming, misalignment,
// flush, mid-stream reset and counter saturation.
module tb_psum_deskew_buffer;
  import pe_array_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  psum_deskew_buffer_if bus ();

  psum_deskew_buffer #(.LATENCY(MAC_LATENCY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush    = 1'b0;
    bus.clr_err  = 1'b0;
    bus.psum_in  = '0;
    bus.in_valid = '0;
  endtask

  task automatic drive_col(input int c, input logic [15:0] d);
    bus.in_valid[c]       = 1'b1;
    bus.psum_in[c*16 +: 16] = d;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Single-vector stimulus: column c carries 16'h0011*(c+1) at cycle 9c.
  task automatic drive_single(input int t);
    for (int c = 0; c < 4; c++)
      if (t == 9 * c) drive_col(c, 16'(16'h0011 * (c + 1)));
  endtask

  initial begin
    // Reset values
    do_reset();
    check("rst_psum_out", bus.psum_out, 64'h0);
    check("rst_out_valid", 64'(bus.out_valid), 64'h0);
    check("rst_align_err", 64'(bus.align_err), 64'h0);
    check("rst_out_count", 64'(bus.out_count), 64'h0);

    // Single aligned vector
    for (int t = 0; t <= 40; t++) begin
      idle_inputs();
      drive_single(t);
      check("single_valid", 64'(bus.out_valid), 64'(t == 28));
      if (t == 28) check("single_psum", bus.psum_out, 64'h0044_0033_0022_0011);
      check("single_err", 64'(bus.align_err), 64'h0);
      tick();
    end
    check("single_count", 64'(bus.out_count), 64'd1);

    // Streaming: ten back-to-back skewed vectors
    do_reset();
    for (int k = 0; k < 10; k++)
      exp_q.push_back({16'(256*k + 3), 16'(256*k + 2), 16'(256*k + 1), 16'(256*k)});
    for (int t = 0; t <= 45; t++) begin
      idle_inputs();
      for (int c = 0; c < 4; c++) begin
        int k;
        k = t - 9 * c;
        if (k >= 0 && k < 10) drive_col(c, 16'(256*k + c));
      end
      check("stream_valid", 64'(bus.out_valid), 64'(t >= 28 && t <= 37));
      if (bus.out_valid) begin
        if (exp_q.size() == 0) check("stream_extra", 64'h1, 64'h0);
        else check("stream_vec", bus.psum_out, exp_q.pop_front());
      end
      check("stream_err", 64'(bus.align_err), 64'h0);
      tick();
    end
    check("stream_left", 64'(exp_q.size()), 64'd0);
    check("stream_count", 64'(bus.out_count), 64'd10);

    // Reset mid-stream (state carries over from streaming, so zeroing is observable)
    for (int t = 0; t <= 45; t++) begin
      idle_inputs();
      drive_single(t);
      if (t == 16) rst = 1'b0;
      if (t == 15) begin
        rst = 1'b1;
        #1;
        check("arst_psum", bus.psum_out, 64'h0);
        check("arst_valid", 64'(bus.out_valid), 64'h0);
        check("arst_err", 64'(bus.align_err), 64'h0);
        check("arst_count", 64'(bus.out_count), 64'h0);
      end
      check("arst_nodata", 64'(bus.out_valid), 64'h0);
      // Columns 2 and 3 still arrive after release and meet without columns 0/1.
      check("arst_orphan_err", 64'(bus.align_err), 64'(t >= 28));
      tick();
    end
    check("arst_count_end", 64'(bus.out_count), 64'h0);

    // Misalignment: column 1 one cycle early
    do_reset();
    for (int t = 0; t <= 45; t++) begin
      idle_inputs();
      if (t == 0)  drive_col(0, 16'h0011);
      if (t == 8)  drive_col(1, 16'h0022);
      if (t == 18) drive_col(2, 16'h0033);
      if (t == 27) drive_col(3, 16'h0044);
      if (t == 40) bus.clr_err = 1'b1;
      check("mis_valid", 64'(bus.out_valid), 64'h0);
      if (t <= 26) check("mis_err_pre", 64'(bus.align_err), 64'h0);
      if (t >= 28 && t <= 40) check("mis_err_held", 64'(bus.align_err), 64'h1);
      if (t >= 41) check("mis_err_clr", 64'(bus.align_err), 64'h0);
      tick();
    end
    check("mis_count", 64'(bus.out_count), 64'h0);

    // Flush mid-flight, with a competing in_valid on the flush cycle, then a fresh vector
    do_reset();
    for (int t = 0; t <= 60; t++) begin
      idle_inputs();
      if (t < 20) drive_single(t);
      if (t == 20) begin
        bus.flush = 1'b1;
        drive_col(0, 16'hdead);
      end
      for (int c = 0; c < 4; c++)
        if (t == 21 + 9 * c) drive_col(c, 16'(16'h0a0a + c));
      check("flush_valid", 64'(bus.out_valid), 64'(t == 49));
      if (t == 49) check("flush_psum", bus.psum_out, 64'h0a0d_0a0c_0a0b_0a0a);
      check("flush_err", 64'(bus.align_err), 64'h0);
      tick();
    end
    check("flush_count", 64'(bus.out_count), 64'd1);

    // Saturation: continuous aligned stream; count at cycle t is t-27 until it pins
    do_reset();
    bus.in_valid = '1;
    for (int t = 0; t <= 70030; t++) begin
      if (t == 65561) check("sat_before", 64'(bus.out_count), 64'd65534);
      if (t == 65563) check("sat_reach", 64'(bus.out_count), 64'hffff);
      tick();
    end
    check("sat_hold", 64'(bus.out_count), 64'hffff);
    check("sat_valid", 64'(bus.out_valid), 64'h1);
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/psum_deskew_buffer.md
Name: psum_deskew_buffer

Overview:
- Output-side counterpart to the ifmap skew stage of the 4x4 systolic PE array.
- Column c partial sums leave the array c*LATENCY cycles after column 0. This block re-delays each column so that all four columns are realigned into one 64-bit vector.
- Tracks per-column valid bits, flags misalignment, and counts emitted vectors.
- Sits between the PE array south edge and the ofmap writeback logic.

Parameters:
- LATENCY, 9, MAC pipeline latency per PE hop; must be >= 1.
- DATA_W, 16, bits per column result.
- NUM_COLS, 4, array columns; fixed at 4 for this revision.
- CNT_W, 16, width of the emitted-vector counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous discard of all in-flight samples.
- clr_err  in  1  synchronous clear of align_err.
- psum_in  in  64  column c result on [16c+15:16c].
- in_valid  in  4  bit c qualifies column c of psum_in.
- psum_out  out  64  realigned vector; column c on [16c+15:16c].
- out_valid  out  1  psum_out holds a fully aligned vector.
- align_err  out  1  sticky misalignment flag.
- out_count  out  16  number of aligned vectors emitted, saturating.

Behaviour:
- Delay per column (data and valid together): column c passes through a shift line of depth (3-c)*LATENCY. With LATENCY=9 the depths are 27, 18, 9 and 0 for columns 0 to 3. Column 3 has no shift line.
- Output register: all outputs are registered. Total latency from input to psum_out/out_valid is (3-c)*LATENCY + 1 cycles for column c, i.e. 28 cycles from a column-0 sample at LATENCY=9.
- Alignment: let dv[3:0] be the valid bits at the shift-line taps (column 3 uses in_valid[3] directly). Each cycle:
  - out_valid <= &dv.
  - psum_out <= tap data whenever &dv. When out_valid is low, psum_out holds its previous value; it is not zeroed.
- align_err: set on any cycle where dv is neither 4'b0000 nor 4'b1111. It is sticky until clr_err.
  - If clr_err and a new error occur in the same cycle, set wins.
  - align_err asserts in the same cycle out_valid would have asserted.
- out_count: increments by 1 on each cycle out_valid is loaded high. It saturates at 16'hFFFF and never wraps. Only rst clears it.
- flush: on a cycle with flush=1:
  - All valid bits in every shift line are cleared, and the incoming in_valid for that cycle is written as 0.
  - out_valid <= 0.
  - Data bits are not cleared.
  - flush wins over simultaneous in_valid.
  - The first sample after flush is taken on the next cycle.
- Reset: asynchronous. psum_out=0, out_valid=0, align_err=0, out_count=0, all shift-line data and valid bits = 0. Reset mid-stream discards in-flight samples; no partial vector is emitted after release.
- Throughput: one vector per cycle, with no backpressure. Downstream must accept every out_valid pulse.
- Gaps: bubbles in in_valid propagate as bubbles in out_valid. Correctly skewed bubbles do not raise align_err.

Decomposition:
- Shared package pe_array_pkg:
  - NUM_COLS=4, DATA_W=16, MAC_LATENCY=9.
  - A typedef for a column word.
  - The same constants are shared with the ifmap skew stage, so skew and deskew always match.
- Sub-module valid_delay_line:
  - Parameters DEPTH and WIDTH.
  - Shifts {valid, data} each cycle, with async reset and synchronous flush that clears valid bits only.
  - Instantiated three times, with DEPTH = 3L, 2L and L.

Test Plan:
- Single aligned vector (L=9): col0=16'h0011 at t0, col1=16'h0022 at t9, col2=16'h0033 at t18, col3=16'h0044 at t27, each valid for 1 cycle -> out_valid high only at t28, psum_out=64'h0044_0033_0022_0011, out_count=1, align_err=0.
- Streaming: 10 consecutive correctly skewed vectors with col c data = 16'h0100*k + c for k=0..9 -> out_valid high t28..t37, vector k matches its inputs, out_count=10.
- Misalignment: col1 valid at t8 instead of t9, others as in the first test -> align_err=1 from t28 and held; out_valid never high. clr_err at t40 -> align_err=0 at t41.
- Flush mid-flight: start the first-test stimulus, pulse flush at t20 -> no out_valid through t60. A fresh stimulus started at t21 emits at t49.
- Reset mid-stream: assert rst at t15 of the first test, release at t16 -> all outputs 0 immediately; no out_valid thereafter.
- Saturation: force 70000 aligned vectors -> out_count holds 16'hFFFF with no wrap.
